// File: rtl/ram_dual_port.sv
// Simple dual-port RAM: one write port and one read port on one clock.
// Registered read data with a write-first bypass and range error flag.
module ram_dual_port #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_enb,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_enb,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  wr_ack,
  output logic                  addr_err
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } port_st_e;

  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] LIMIT =
    (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  port_st_e              wr_st;
  port_st_e              rd_st;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  wr_hit;
  logic                  rd_hit;
  logic                  bypass;
  logic [DATA_WIDTH-1:0] rd_word;

  assign wr_ok  = {1'b0, wr_addr} < LIMIT;
  assign rd_ok  = {1'b0, rd_addr} < LIMIT;
  assign wr_hit = wr_enb & wr_ok;
  assign rd_hit = rd_enb & rd_ok;
  assign bypass = wr_hit & rd_hit
                & (wr_addr == rd_addr);

  assign rd_word = bypass ? data_in
                 : mem[rd_addr];

  always_ff @(posedge clk) begin
    if (wr_hit) begin
      mem[wr_addr] <= data_in;
    end
  end

  // The write port only enters ACCESS for a committed write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_st    <= IDLE;
      rd_st    <= IDLE;
      data_out <= '0;
      addr_err <= 1'b0;
    end else begin
      wr_st    <= wr_hit ? ACCESS : IDLE;
      rd_st    <= rd_enb ? ACCESS : IDLE;
      addr_err <= (wr_enb & ~wr_ok)
                | (rd_enb & ~rd_ok);
      if (rd_enb) begin
        data_out <= rd_ok ? rd_word : '0;
      end
    end
  end

  assign wr_ack   = (wr_st == ACCESS);
  assign rd_valid = (rd_st == ACCESS);

endmodule

// File: tb/tb_ram_dual_port.sv
// Randomized bench for ram_dual_port: two instances (DEPTH 16 and 12)
// share stimulus and are compared against a behavioural memory model.
module tb_ram_dual_port;

  logic       clk;
  logic       rst_n;
  logic       wr_enb;
  logic [3:0] wr_addr;
  logic [7:0] data_in;
  logic       rd_enb;
  logic [3:0] rd_addr;
  logic [7:0] dout [2];
  logic       vld  [2];
  logic       ack  [2];
  logic       err  [2];

  int errs;
  int checks;

  bit [7:0] m      [2][16];
  bit       mk     [2][16];
  bit [7:0] e_do   [2];
  bit       e_kn   [2];
  bit       e_ack  [2];
  bit       e_vld  [2];
  bit       e_err  [2];

  ram_dual_port #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16)
  ) u_d16 (
    .clk(clk), .rst_n(rst_n),
    .wr_enb(wr_enb), .wr_addr(wr_addr),
    .data_in(data_in),
    .rd_enb(rd_enb), .rd_addr(rd_addr),
    .data_out(dout[0]), .rd_valid(vld[0]),
    .wr_ack(ack[0]), .addr_err(err[0])
  );

  ram_dual_port #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12)
  ) u_d12 (
    .clk(clk), .rst_n(rst_n),
    .wr_enb(wr_enb), .wr_addr(wr_addr),
    .data_in(data_in),
    .rd_enb(rd_enb), .rd_addr(rd_addr),
    .data_out(dout[1]), .rd_valid(vld[1]),
    .wr_ack(ack[1]), .addr_err(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dep(int k);
    return (k == 0) ? 16 : 12;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0h want %0h",
               nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      e_do[k]  = 8'h00;
      e_kn[k]  = 1'b1;
      e_ack[k] = 1'b0;
      e_vld[k] = 1'b0;
      e_err[k] = 1'b0;
    end
  endtask

  // Expected outputs after one clock edge with the current inputs.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit wok;
      bit rok;
      wok = int'(wr_addr) < dep(k);
      rok = int'(rd_addr) < dep(k);
      e_ack[k] = wr_enb && wok;
      e_vld[k] = rd_enb;
      e_err[k] = (wr_enb && !wok) || (rd_enb && !rok);
      if (rd_enb) begin
        if (!rok) begin
          e_do[k] = 8'h00;
          e_kn[k] = 1'b1;
        end else if (wr_enb && wok && wr_addr == rd_addr) begin
          e_do[k] = data_in;
          e_kn[k] = 1'b1;
        end else begin
          e_do[k] = m[k][rd_addr];
          e_kn[k] = mk[k][rd_addr];
        end
      end
      if (wr_enb && wok) begin
        m[k][wr_addr]  = data_in;
        mk[k][wr_addr] = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("wr_ack[%0d]", k), 32'(ack[k]), 32'(e_ack[k]));
      chk($sformatf("rd_valid[%0d]", k), 32'(vld[k]), 32'(e_vld[k]));
      chk($sformatf("addr_err[%0d]", k), 32'(err[k]), 32'(e_err[k]));
      if (e_kn[k]) begin
        chk($sformatf("data_out[%0d]", k), 32'(dout[k]), 32'(e_do[k]));
      end
    end
  endtask

  task automatic cyc(input bit we, input bit [3:0] wa,
                     input bit [7:0] di, input bit re,
                     input bit [3:0] ra);
    wr_enb  = we;
    wr_addr = wa;
    data_in = di;
    rd_enb  = re;
    rd_addr = ra;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int cnt;
    errs    = 0;
    checks  = 0;
    rst_n   = 1'b0;
    wr_enb  = 1'b0;
    wr_addr = '0;
    data_in = '0;
    rd_enb  = 1'b0;
    rd_addr = '0;
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 16; a++)
        mk[k][a] = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    cyc(1, 4'd3, 8'hA5, 0, 4'd0);
    chk("wr_ack after write 3", 32'(ack[0]), 32'd1);
    cyc(0, 4'd0, 8'h00, 1, 4'd3);
    chk("read 3 data", 32'(dout[0]), 32'hA5);
    chk("read 3 valid", 32'(vld[0]), 32'd1);
    chk("wr_ack one cycle", 32'(ack[0]), 32'd0);

    cyc(1, 4'd7, 8'h3C, 1, 4'd7);
    chk("bypass d16", 32'(dout[0]), 32'h3C);
    chk("bypass d12", 32'(dout[1]), 32'h3C);

    for (int a = 0; a < 16; a++)
      cyc(1, 4'(a), 8'(a ^ 8'hFF), 0, 4'd0);
    cnt = 0;
    for (int a = 0; a < 16; a++) begin
      cyc(0, 4'd0, 8'h00, 1, 4'(a));
      if (vld[0]) cnt++;
    end
    chk("sweep valid pulses", 32'(cnt), 32'd16);
    chk("sweep last data", 32'(dout[0]), 32'hF0);

    cyc(1, 4'd13, 8'h55, 0, 4'd0);
    chk("oor write err", 32'(err[1]), 32'd1);
    chk("oor write ack", 32'(ack[1]), 32'd0);
    cyc(0, 4'd0, 8'h00, 1, 4'd13);
    chk("oor read data", 32'(dout[1]), 32'h00);
    chk("oor read valid", 32'(vld[1]), 32'd1);
    chk("oor read err", 32'(err[1]), 32'd1);
    chk("d16 read 13", 32'(dout[0]), 32'h55);

    cyc(1, 4'd5, 8'h42, 0, 4'd0);
    cyc(0, 4'd0, 8'h00, 1, 4'd5);
    chk("idle pre data", 32'(dout[0]), 32'h42);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 4'd0, 8'h00, 0, 4'd0);
      chk("idle hold data", 32'(dout[0]), 32'h42);
      chk("idle hold valid", 32'(vld[0]), 32'd0);
    end

    cyc(0, 4'd0, 8'h00, 1, 4'd5);
    rd_enb  = 1'b1;
    rd_addr = 4'd5;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst data", 32'(dout[0]), 32'h00);
    chk("async rst valid", 32'(vld[0]), 32'd0);
    model_reset();
    compare_all();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rd_enb = 1'b0;
    rst_n  = 1'b1;

    for (int i = 0; i < 400; i++) begin
      bit [3:0] wa;
      bit [3:0] ra;
      wa = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa
         : 4'($urandom_range(0, 15));
      cyc(1'($urandom), wa, 8'($urandom),
          1'($urandom), ra);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
